frame_downscale_writer: RTL and testbench
=========================================

# frame_downscale_writer

Write-side companion to the display-side address scaler. Takes the raw camera pixel stream in raster order and box-averages it down by the same factors the display side scales up: 1X, 2X×2X, or 4X horizontal × 2X vertical. Writes the result into the 240×320 RGB565 frame buffer, so a scaled-up readout reproduces the full camera field. Sits between the camera pixel reconstructor and the frame-buffer BRAM write port.

## Interface
Parameters:
- `FB_W`, default 240: frame-buffer width in pixels.
- `FB_H`, default 320: frame-buffer height in pixels.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `scale_in` in 2: scale mode, same encoding as the display side.
  - `2'b10`: 4X H × 2X V.
  - `2'b11`: 2X × 2X.
  - Other values: 1X.
- `pixel_valid_in` in 1: qualifies `hcount_in`, `vcount_in` and `pixel_in`.
- `hcount_in` in 11: camera column.
- `vcount_in` in 10: camera row.
- `pixel_in` in 16: RGB565 pixel.
- `addr_out` out 17: frame-buffer write address.
- `pixel_out` out 16: averaged RGB565 pixel.
- `we_out` out 1: write enable.
- `frame_done_out` out 1: one-cycle pulse on the final write of a frame.

## Operation
- **Block size.** The block is BW×BH.
  - 1X: 1×1.
  - 2'b11: 2×2.
  - 2'b10: 4×2.
  - Shifts: hs = log2 BW, vs = log2 BH.
- **FSM states.**
  - WAIT_SOF to ACTIVE: on `pixel_valid_in` with hcount=0 and vcount=0.
    - Latch `scale_in` into `scale_q`.
    - Clear the horizontal accumulators.
    - Process that pixel.
  - ACTIVE to WAIT_SOF: after the write to address FB_W*FB_H−1.
  - ACTIVE, on a new SOF (hcount=0, vcount=0 valid): relatch scale and restart. This is a truncated frame; no `frame_done_out` is issued.
- **Scale changes.** `scale_in` changes mid-frame are ignored until the next SOF.
- **Input rules.**
  - Raster order, at most one valid pixel per clock. Gaps are allowed.
  - Pixels with hcount ≥ FB_W·BW or vcount ≥ FB_H·BH are dropped and do not touch any accumulator.
- **Accumulation.**
  - Channel sums are kept separately: R and B 8 bits each, G 9 bits.
  - Horizontal: sum BW consecutive pixels in registers. The sum resets when hcount[hs−1:0]=0.
  - Vertical, row phase `vcount[vs−1:0]`=0 with BH=2: write the horizontal partial sum (25 bits) to line-buffer entry `hcount>>hs`. Nothing is written to the frame buffer.
  - Vertical, last row of the block: read the line-buffer entry, add the horizontal sum, and emit.
  - BH=1: the line buffer is bypassed.
- **Averaging.**
  - Each channel total is shifted right by hs+vs, i.e. divided by 1, 4 or 8. Truncation, no rounding.
  - The result is repacked as RGB565.
- **Address.** addr = (vcount>>vs)·FB_W + (hcount>>hs). Computed with a constant-multiply shift-add, 17-bit result, no overflow within range.
- **Reset values.** All outputs 0, FSM in WAIT_SOF, `scale_q` = 1X, all accumulators 0.
  - Reset mid-frame: outputs drop immediately. No writes occur until the next SOF.
  - Line-buffer contents are don't-care, because they are always overwritten before being read.

## Timing
- **Output latency.** Registered outputs. `we_out` asserts exactly 2 cycles after the valid cycle carrying the last pixel of a block, in every mode, including the 1X bypass path.
- **Line buffer.** Read latency is 1 cycle. The read address is issued with the block's first pixel on the last row. The read data is consumed in pipeline stage 1.
- **Throughput.** One input pixel per cycle sustained. `we_out` is never asserted on two writes to the same address within a frame.
- **Address and data.** `addr_out` and `pixel_out` are valid only when `we_out`=1; otherwise they hold their last value.
- **Frame done.** `frame_done_out` coincides with the `we_out` of address 76799 (FB_W·FB_H−1).
- **Back-to-back frames.** A new-frame SOF arriving in the same cycle as the previous frame's final pipeline write is accepted: the final write completes and the new frame begins.

## Structure
- **Shared package** `scale_pkg` holds:
  - The `scale_mode_t` enum: `SCALE_1X` = 2'b00/01, `SCALE_4H2V` = 2'b10, `SCALE_2X` = 2'b11.
  - `FB_W` and `FB_H`.
  - Channel-sum widths.
  - Helper functions `hshift(mode)` and `vshift(mode)`.
  - The display-side scaler also imports this package.
- **Sub-module** `line_accum_buf`: 240×25-bit simple dual-port RAM, one write port and one registered read port, inferred BRAM.

## Test plan
- **1X pass-through.** Reset, SOF, scale=00, 240×320 frame with pixel = hcount.
  - Expect 76800 writes.
  - Expect addr = v·240+h and data equal to the input, each 2 cycles after its input.
  - Expect `frame_done_out` once, with addr 76799.
- **2X averaging.** scale=11, 480×640 frame, pixels with R=4, G=8, B=2 everywhere except block (0,0).
  - Block (0,0) pixels: R = 0, 1, 2, 3. Expect that write to have R=1 (6>>2).
  - Expect all other writes to be 16'h2102.
- **4H2V.** scale=10, 960×640 frame.
  - Expect addr for input (h=963, v=3) to land at 1·240+240 → out of range, dropped. Expect no write.
  - Expect input (h=959, v=639) to produce write addr 76799.
- **Mid-frame scale change and gaps.** Switch `scale_in` 00→11 at v=100 with random `pixel_valid_in` gaps.
  - Expect 1X behaviour for the whole frame.
  - Expect 2X behaviour starting from the next SOF.
- **Reset mid-frame.** Assert `rst_in` asynchronously at v=50.
  - Expect `we_out`=0 immediately.
  - Feed the remaining rows without an SOF: expect no writes.
  - Next SOF: expect a clean, full frame.
- **Back-to-back frames.** SOF in the cycle right after the last pixel of the previous frame.
  - Expect the final write and `frame_done_out` to be intact.
  - Expect the new frame's first write to be correct.

Source files
------------

// File: rtl/scale_pkg.sv
// Scale-mode encoding, frame-buffer geometry and channel-sum helpers shared by
// the camera write side and the display read side.
package scale_pkg;

  typedef enum logic [1:0] {
    SCALE_1X     = 2'b00,
    SCALE_1X_ALT = 2'b01,
    SCALE_4H2V   = 2'b10,
    SCALE_2X     = 2'b11
  } scale_mode_t;

  localparam int FB_W = 240;
  localparam int FB_H = 320;

  // Wide enough for an 8-pixel box: 8*31 and 8*63 fit without overflow.
  localparam int SUM_R_W = 8;
  localparam int SUM_G_W = 9;
  localparam int SUM_B_W = 8;
  localparam int SUM_W   = SUM_R_W + SUM_G_W + SUM_B_W;

  typedef struct packed {
    logic [SUM_R_W-1:0] r;
    logic [SUM_G_W-1:0] g;
    logic [SUM_B_W-1:0] b;
  } ch_sum_t;

  function automatic logic [1:0] hshift(input scale_mode_t mode);
    case (mode)
      SCALE_4H2V: return 2'd2;
      SCALE_2X:   return 2'd1;
      default:    return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] vshift(input scale_mode_t mode);
    case (mode)
      SCALE_4H2V, SCALE_2X: return 2'd1;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic ch_sum_t px_to_sum(input logic [15:0] px);
    ch_sum_t s;
    s.r = SUM_R_W'(px[15:11]);
    s.g = SUM_G_W'(px[10:5]);
    s.b = SUM_B_W'(px[4:0]);
    return s;
  endfunction

  function automatic ch_sum_t sum_add(input ch_sum_t a, input ch_sum_t b);
    ch_sum_t s;
    s.r = a.r + b.r;
    s.g = a.g + b.g;
    s.b = a.b + b.b;
    return s;
  endfunction

endpackage

// File: rtl/frame_downscale_writer_if.sv
// Camera pixel stream in, frame-buffer write port out.
interface frame_downscale_writer_if;
  logic [1:0]  scale_in;
  logic        pixel_valid_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [15:0] pixel_in;
  logic [16:0] addr_out;
  logic [15:0] pixel_out;
  logic        we_out;
  logic        frame_done_out;

  modport master (
    output scale_in, pixel_valid_in, hcount_in, vcount_in, pixel_in,
    input  addr_out, pixel_out, we_out, frame_done_out
  );

  modport slave (
    input  scale_in, pixel_valid_in, hcount_in, vcount_in, pixel_in,
    output addr_out, pixel_out, we_out, frame_done_out
  );
endinterface

// File: rtl/line_accum_buf.sv
// Simple dual-port line buffer holding the first-row horizontal partial sums.
module line_accum_buf #(
  parameter int DEPTH = 240,
  parameter int AW    = 8,
  parameter int DW    = 25
) (
  input  logic          clk_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds between reads; the consuming stage relies on that.
  always_ff @(posedge clk_in) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_downscale_writer.sv
// Box-averages the camera raster by 1x1, 2x2 or 4x2 and writes RGB565 into the frame buffer.
//   state    | meaning
//   WAIT_SOF | idle; only a valid pixel at (0,0) starts a frame
//   ACTIVE   | accumulating a frame with the scale latched at SOF
module frame_downscale_writer #(
  parameter int FB_W = scale_pkg::FB_W,
  parameter int FB_H = scale_pkg::FB_H
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  frame_downscale_writer_if.slave  bus
);
  import scale_pkg::*;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  localparam int          LB_AW     = $clog2(FB_W);
  localparam logic [10:0] H_LIM     = 11'(FB_W);
  localparam logic [9:0]  V_LIM     = 10'(FB_H);
  localparam logic [16:0] LAST_ADDR = 17'(FB_W * FB_H - 1);

  // row * FB_W as a sum of shifted copies, one per set bit of the constant.
  function automatic logic [16:0] row_base(input logic [9:0] row);
    logic [16:0] acc;
    acc = '0;
    for (int i = 0; i < 17; i++) begin
      if (FB_W[i]) acc = acc + (17'(row) << i);
    end
    return acc;
  endfunction

  state_t      state, state_nxt;
  scale_mode_t scale_q, scale_nxt, mode;

  logic        sof, accept, emit, h_first, h_last, v_last, lb_wr, lb_rd;
  logic [1:0]  hs, vs, hmask, hphase;
  logic [10:0] hblk;
  logic [9:0]  vblk;
  logic [16:0] addr_nxt;
  ch_sum_t     hacc, hsum_nxt, lb_rd_data, tot;

  logic        s1_valid, s1_use_lb, s1_last;
  logic [1:0]  s1_shift;
  logic [16:0] s1_addr;
  ch_sum_t     s1_sum;

  logic        we_q, done_q;
  logic [16:0] addr_q;
  logic [15:0] pix_q, pix_nxt;

  always_comb begin
    sof      = bus.pixel_valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);
    mode     = sof ? scale_mode_t'(bus.scale_in) : scale_q;
    hs       = hshift(mode);
    vs       = vshift(mode);
    hmask    = {hs[1], hs != 2'd0};
    hphase   = bus.hcount_in[1:0] & hmask;
    h_first  = (hphase == 2'b00);
    h_last   = (hphase == hmask);
    v_last   = (vs == 2'd0) || bus.vcount_in[0];
    hblk     = bus.hcount_in >> hs;
    vblk     = bus.vcount_in >> vs;
    accept   = bus.pixel_valid_in && (sof || state == ACTIVE) &&
               (hblk < H_LIM) && (vblk < V_LIM);
    hsum_nxt = h_first ? px_to_sum(bus.pixel_in)
                       : sum_add(hacc, px_to_sum(bus.pixel_in));
    lb_wr    = accept && (vs != 2'd0) && !bus.vcount_in[0] && h_last;
    lb_rd    = accept && (vs != 2'd0) && bus.vcount_in[0] && h_first;
    emit     = accept && h_last && v_last;
    addr_nxt = row_base(vblk) + 17'(hblk);
  end

  always_comb begin
    state_nxt = state;
    scale_nxt = scale_q;
    if (sof) begin
      state_nxt = ACTIVE;
      scale_nxt = scale_mode_t'(bus.scale_in);
    end
    if (emit && addr_nxt == LAST_ADDR) state_nxt = WAIT_SOF;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= WAIT_SOF;
      scale_q <= SCALE_1X;
    end else begin
      state   <= state_nxt;
      scale_q <= scale_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) hacc <= '0;
    else if (accept) hacc <= hsum_nxt;
  end

  line_accum_buf #(
    .DEPTH (FB_W),
    .AW    (LB_AW),
    .DW    (SUM_W)
  ) u_line_buf (
    .clk_in  (clk_in),
    .wr_en   (lb_wr),
    .wr_addr (hblk[LB_AW-1:0]),
    .wr_data (hsum_nxt),
    .rd_en   (lb_rd),
    .rd_addr (hblk[LB_AW-1:0]),
    .rd_data (lb_rd_data)
  );

  // Stage 1 carries its own shift so a scale relatch at SOF cannot touch a block in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid  <= 1'b0;
      s1_use_lb <= 1'b0;
      s1_last   <= 1'b0;
      s1_shift  <= '0;
      s1_addr   <= '0;
      s1_sum    <= '0;
    end else begin
      s1_valid <= emit;
      if (emit) begin
        s1_use_lb <= (vs != 2'd0);
        s1_last   <= (addr_nxt == LAST_ADDR);
        s1_shift  <= hs + vs;
        s1_addr   <= addr_nxt;
        s1_sum    <= hsum_nxt;
      end
    end
  end

  always_comb begin
    tot     = s1_use_lb ? sum_add(s1_sum, lb_rd_data) : s1_sum;
    pix_nxt = {5'(tot.r >> s1_shift), 6'(tot.g >> s1_shift), 5'(tot.b >> s1_shift)};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      pix_q  <= '0;
    end else begin
      we_q   <= s1_valid;
      done_q <= s1_valid && s1_last;
      if (s1_valid) begin
        addr_q <= s1_addr;
        pix_q  <= pix_nxt;
      end
    end
  end

  assign bus.we_out         = we_q;
  assign bus.frame_done_out = done_q;
  assign bus.addr_out       = addr_q;
  assign bus.pixel_out      = pix_q;

endmodule

// File: tb/tb_frame_downscale_writer.sv
// Directed bench: a reduced 16x8 frame buffer for whole-frame checks, default geometry for corner addresses.
module tb_frame_downscale_writer;

  localparam int W = 16;
  localparam int H = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  frame_downscale_writer_if sm ();
  frame_downscale_writer_if bg ();

  frame_downscale_writer #(.FB_W(W), .FB_H(H)) dut_small (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (sm)
  );

  frame_downscale_writer dut_big (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int stray_fd = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  int          exp_addr[$], exp_cyc[$];
  logic [15:0] exp_data[$];
  bit          exp_fd[$];
  int          got_addr[$], got_cyc[$];
  logic [15:0] got_data[$];
  bit          got_fd[$];
  int          big_addr[$];
  logic [15:0] big_data[$];
  bit          big_fd[$];

  always @(negedge clk_in) begin
    if (sm.we_out) begin
      got_addr.push_back(int'(sm.addr_out));
      got_data.push_back(sm.pixel_out);
      got_fd.push_back(sm.frame_done_out);
      got_cyc.push_back(cyc);
    end else if (sm.frame_done_out) begin
      stray_fd++;
    end
    if (bg.we_out) begin
      big_addr.push_back(int'(bg.addr_out));
      big_data.push_back(bg.pixel_out);
      big_fd.push_back(bg.frame_done_out);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // dm 0: pixel = hcount; dm 1: 2x2 pattern; dm 2: 4x2 pattern. Dropped region is all ones.
  function automatic logic [15:0] stim_pix(input int dm, input int h, input int v,
                                           input int bw, input int bh);
    if (h >= W * bw || v >= H * bh) return 16'hFFFF;
    case (dm)
      0: return 16'(h);
      1: begin
        if (h < 2 && v < 2)  return {5'(h + 2 * v), 6'd8, 5'd2};
        if (h == 2 && v == 1) return {5'd4, 6'd8, 5'd30};
        return 16'h2102;
      end
      default: begin
        if (h == 0 && v == 0) return {5'd31, 6'd8, 5'd2};
        if (h == 5 && v == 1) return {5'd4, 6'd63, 5'd2};
        return 16'h2102;
      end
    endcase
  endfunction

  // Hand-computed block averages for the patterns above.
  function automatic logic [15:0] exp_pix(input int dm, input int a);
    case (dm)
      0: return 16'(a % W);
      1: return (a == 0) ? 16'h0902 : (a == 1) ? 16'h2109 : 16'h2102;
      default: return (a == 0) ? 16'h3902 : (a == 1) ? 16'h21C2 : 16'h2102;
    endcase
  endfunction

  task automatic send(input int h, input int v, input int dm, input int bw, input int bh,
                      input bit track);
    int a;
    @(posedge clk_in); #1;
    sm.pixel_valid_in = 1'b1;
    sm.hcount_in      = 11'(h);
    sm.vcount_in      = 10'(v);
    sm.pixel_in       = stim_pix(dm, h, v, bw, bh);
    if (track && h < W * bw && v < H * bh && (h % bw) == bw - 1 && (v % bh) == bh - 1) begin
      a = (v / bh) * W + h / bw;
      exp_addr.push_back(a);
      exp_data.push_back(exp_pix(dm, a));
      exp_fd.push_back(a == W * H - 1);
      exp_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      sm.pixel_valid_in = 1'b0;
    end
  endtask

  task automatic run_frame(input int dm, input logic [1:0] sc, input int bw, input int bh,
                           input int cols, input int rows, input int sw_row,
                           input logic [1:0] sc2, input bit gaps);
    sm.scale_in = sc;
    for (int v = 0; v < rows; v++) begin
      for (int h = 0; h < cols; h++) begin
        if (v == sw_row && h == 0) sm.scale_in = sc2;
        send(h, v, dm, bw, bh, 1'b1);
        if (gaps && $urandom_range(3) == 0) idle($urandom_range(2, 1));
      end
    end
  endtask

  task automatic flush();
    exp_addr.delete(); exp_data.delete(); exp_fd.delete(); exp_cyc.delete();
    got_addr.delete(); got_data.delete(); got_fd.delete(); got_cyc.delete();
  endtask

  task automatic finish_check(input string tag);
    idle(6);
    check_val({tag, " count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check_val($sformatf("%s addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
      check_val($sformatf("%s data[%0d]", tag, i), got_data[i], exp_data[i]);
      check_val($sformatf("%s done[%0d]", tag, i), got_fd[i], exp_fd[i]);
      check_val($sformatf("%s latency[%0d]", tag, i), got_cyc[i] - exp_cyc[i], 2);
    end
    flush();
  endtask

  task automatic bsend(input int h, input int v, input logic [15:0] p);
    @(posedge clk_in); #1;
    bg.pixel_valid_in = 1'b1;
    bg.hcount_in      = 11'(h);
    bg.vcount_in      = 10'(v);
    bg.pixel_in       = p;
  endtask

  task automatic bidle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      bg.pixel_valid_in = 1'b0;
    end
  endtask

  initial begin
    sm.scale_in = 2'b00; sm.pixel_valid_in = 1'b0; sm.hcount_in = '0;
    sm.vcount_in = '0;   sm.pixel_in = '0;
    bg.scale_in = 2'b00; bg.pixel_valid_in = 1'b0; bg.hcount_in = '0;
    bg.vcount_in = '0;   bg.pixel_in = '0;

    repeat (3) @(posedge clk_in);
    #1;
    check_val("reset we",   sm.we_out, 0);
    check_val("reset done", sm.frame_done_out, 0);
    check_val("reset addr", sm.addr_out, 0);
    check_val("reset pix",  sm.pixel_out, 0);
    rst_in = 1'b0;

    run_frame(0, 2'b00, 1, 1, W, H, -1, 2'b00, 1'b0);
    finish_check("1x");

    run_frame(1, 2'b11, 2, 2, 2 * W, 2 * H, -1, 2'b11, 1'b0);
    finish_check("2x");

    // Four extra columns per row land past the buffer and must be dropped.
    run_frame(2, 2'b10, 4, 2, 4 * W + 4, 2 * H, -1, 2'b10, 1'b0);
    finish_check("4h2v");

    run_frame(0, 2'b00, 1, 1, W, H, 4, 2'b11, 1'b1);
    finish_check("scale change");
    run_frame(1, 2'b11, 2, 2, 2 * W, 2 * H, -1, 2'b11, 1'b1);
    finish_check("scale next sof");

    // Reset part-way through a 1X frame while writes are streaming.
    sm.scale_in = 2'b00;
    for (int v = 0; v < 3; v++)
      for (int h = 0; h < W; h++) send(h, v, 0, 1, 1, 1'b1);
    @(posedge clk_in); #1;
    check_val("pre-reset we", sm.we_out, 1);
    rst_in = 1'b1;
    sm.pixel_valid_in = 1'b0;
    #1;
    check_val("async reset we",   sm.we_out, 0);
    check_val("async reset done", sm.frame_done_out, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    flush();
    for (int v = 3; v < H; v++)
      for (int h = 1; h < W; h++) send(h, v, 0, 1, 1, 1'b0);
    idle(6);
    check_val("no sof writes", got_addr.size(), 0);
    flush();
    run_frame(0, 2'b00, 1, 1, W, H, -1, 2'b00, 1'b0);
    finish_check("post reset");

    // Next SOF immediately follows the previous frame's last pixel.
    run_frame(0, 2'b00, 1, 1, W, H, -1, 2'b00, 1'b0);
    run_frame(1, 2'b11, 2, 2, 2 * W, 2 * H, -1, 2'b11, 1'b0);
    finish_check("back to back");

    // Full-size geometry: corner addresses only.
    bg.scale_in = 2'b00;
    bsend(0, 0, 16'h1234);
    bsend(239, 319, 16'hABCD);
    bidle(6);
    check_val("big 1x count", big_addr.size(), 2);
    if (big_addr.size() == 2) begin
      check_val("big 1x addr0", big_addr[0], 0);
      check_val("big 1x data0", big_data[0], 16'h1234);
      check_val("big 1x done0", big_fd[0], 0);
      check_val("big 1x addr1", big_addr[1], 76799);
      check_val("big 1x data1", big_data[1], 16'hABCD);
      check_val("big 1x done1", big_fd[1], 1);
    end
    big_addr.delete(); big_data.delete(); big_fd.delete();

    bg.scale_in = 2'b10;
    bsend(0, 0, 16'h2102);
    bsend(963, 3, 16'hFFFF);
    for (int h = 956; h < 960; h++) bsend(h, 638, 16'h2102);
    for (int h = 956; h < 960; h++) bsend(h, 639, 16'h2102);
    bidle(6);
    check_val("big 4h2v count", big_addr.size(), 1);
    if (big_addr.size() == 1) begin
      check_val("big 4h2v addr", big_addr[0], 76799);
      check_val("big 4h2v data", big_data[0], 16'h2102);
      check_val("big 4h2v done", big_fd[0], 1);
    end

    check_val("stray frame_done", stray_fd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
